// File: rtl/ps2_key_decoder_if.sv
// Scan-code byte stream from the PS/2 byte receiver.
// The receiver drives it as master; the key decoder consumes it as slave.
interface ps2_key_decoder_if;
    logic       ps2_code_new;
    logic [7:0] ps2_code;

    modport master (
        output ps2_code_new,
        output ps2_code
    );

    modport slave (
        input ps2_code_new,
        input ps2_code
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code sequence decoder with held-key bitmap and
// per-player Tron direction registers.
module ps2_key_decoder #(
    parameter int clk_freq       = 50000000,
    parameter int timeout_cycles = clk_freq / 500,
    parameter bit block_reverse  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    ps2_key_decoder_if.slave bus,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_repeat,
    output logic [7:0] keys_held,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic [1:0] dir_changed
);

    localparam int TW = $clog2(timeout_cycles + 1);

    typedef enum logic [2:0] {
        IDLE, EXT, BRK, EXT_BRK, PAUSE
    } state_t;

    state_t        state, next_state;
    logic [2:0]    skip_cnt, next_skip;
    logic [TW-1:0] to_cnt;
    logic          to_hit;

    logic [7:0] code;
    logic       code_new;
    logic       is_e0, is_f0, is_e1, is_prefix, is_discard;

    logic       ev_fire, ev_ext, ev_brk;
    logic       ctrl_hit;
    logic [2:0] ctrl_idx;
    logic [1:0] req;
    logic       load_p1, load_p2;

    assign code     = bus.ps2_code;
    assign code_new = bus.ps2_code_new;

    assign is_e0      = (code == 8'hE0);
    assign is_f0      = (code == 8'hF0);
    assign is_e1      = (code == 8'hE1);
    assign is_prefix  = is_e0 | is_f0 | is_e1;
    assign is_discard = (code == 8'hFA) | (code == 8'hAA) |
                        (code == 8'hEE) | (code == 8'hFE) |
                        (code == 8'h00) | (code == 8'hFF);

    assign to_hit = (state != IDLE) && !code_new &&
                    (to_cnt == TW'(timeout_cycles - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= next_state;
            skip_cnt <= next_skip;
            if (state == IDLE || code_new || to_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_skip  = skip_cnt;
        if (code_new) begin
            unique case (state)
                IDLE, BRK: begin
                    next_state = IDLE;
                    if (is_e0) next_state = EXT;
                    if (is_f0) next_state = BRK;
                    if (is_e1) begin
                        next_state = PAUSE;
                        next_skip  = 3'd7;
                    end
                end
                EXT: begin
                    next_state = IDLE;
                    if (is_e0) next_state = EXT;
                    if (is_f0) next_state = EXT_BRK;
                    if (is_e1) begin
                        next_state = PAUSE;
                        next_skip  = 3'd7;
                    end
                end
                EXT_BRK: next_state = IDLE;
                PAUSE: begin
                    next_skip = skip_cnt - 1'b1;
                    if (skip_cnt <= 3'd1) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end else if (to_hit) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        ev_fire = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (code_new) begin
            unique case (state)
                IDLE: ev_fire = !is_prefix && !is_discard;
                BRK: begin
                    ev_fire = !is_prefix;
                    ev_brk  = 1'b1;
                end
                EXT: begin
                    ev_fire = !is_prefix;
                    ev_ext  = 1'b1;
                end
                EXT_BRK: begin
                    ev_fire = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                end
                default: ev_fire = 1'b0;
            endcase
        end
    end

    // Bitmap index: [1:0] doubles as the direction, [2] selects the player
    always_comb begin
        ctrl_hit = 1'b1;
        ctrl_idx = 3'd0;
        unique case (1'b1)
            (!ev_ext && code == 8'h1D): ctrl_idx = 3'd0;
            (!ev_ext && code == 8'h23): ctrl_idx = 3'd1;
            (!ev_ext && code == 8'h1B): ctrl_idx = 3'd2;
            (!ev_ext && code == 8'h1C): ctrl_idx = 3'd3;
            ( ev_ext && code == 8'h75): ctrl_idx = 3'd4;
            ( ev_ext && code == 8'h74): ctrl_idx = 3'd5;
            ( ev_ext && code == 8'h72): ctrl_idx = 3'd6;
            ( ev_ext && code == 8'h6B): ctrl_idx = 3'd7;
            default:                    ctrl_hit = 1'b0;
        endcase
    end

    assign req = ctrl_idx[1:0];

    assign load_p1 = ev_fire && !ev_brk && ctrl_hit && !ctrl_idx[2] &&
                     (req != p1_dir) &&
                     !(block_reverse && req == (p1_dir ^ 2'b10));

    assign load_p2 = ev_fire && !ev_brk && ctrl_hit && ctrl_idx[2] &&
                     (req != p2_dir) &&
                     !(block_reverse && req == (p2_dir ^ 2'b10));

    always_ff @(posedge clock) begin
        if (reset) begin
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_break   <= 1'b0;
            key_repeat  <= 1'b0;
            keys_held   <= '0;
            p1_dir      <= 2'b01;
            p2_dir      <= 2'b11;
            dir_changed <= '0;
        end else begin
            key_valid   <= ev_fire;
            dir_changed <= {load_p2, load_p1};
            if (ev_fire) begin
                key_code   <= code;
                key_ext    <= ev_ext;
                key_break  <= ev_brk;
                key_repeat <= !ev_brk && ctrl_hit && keys_held[ctrl_idx];
                if (ctrl_hit) keys_held[ctrl_idx] <= !ev_brk;
            end
            if (load_p1) p1_dir <= req;
            if (load_p2) p2_dir <= req;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: one task per scenario,
// inline checks against hand-computed values.
module tb_ps2_key_decoder;

    localparam int TO = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_repeat;
    logic [7:0] keys_held;
    logic [1:0] p1_dir;
    logic [1:0] p2_dir;
    logic [1:0] dir_changed;

    int total = 0;
    int bad   = 0;
    int vcount = 0;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .clk_freq(50000000),
        .timeout_cycles(TO),
        .block_reverse(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ext(key_ext),
        .key_break(key_break),
        .key_repeat(key_repeat),
        .keys_held(keys_held),
        .p1_dir(p1_dir),
        .p2_dir(p2_dir),
        .dir_changed(dir_changed)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        if (key_valid) vcount++;
    end

    task automatic drive(input logic [7:0] b);
        bus.ps2_code_new = 1'b1;
        bus.ps2_code     = b;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        bus.ps2_code_new = 1'b0;
        bus.ps2_code     = 8'h00;
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        bus.ps2_code_new = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({key_valid, key_ext, key_break, key_repeat} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000",
                     {key_valid, key_ext, key_break, key_repeat});
        end
        total++;
        if ({key_code, keys_held} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_code_held got=%h want=0000",
                     {key_code, keys_held});
        end
        total++;
        if ({p1_dir, p2_dir, dir_changed} !== 6'b01_11_00) begin
            bad++;
            $display("FAIL reset_dirs got=%b want=011100",
                     {p1_dir, p2_dir, dir_changed});
        end
    endtask

    task automatic test_make();
        drive(8'h1D);
        total++;
        if ({key_valid, key_code, key_ext, key_break, key_repeat}
            !== {1'b1, 8'h1D, 3'b000}) begin
            bad++;
            $display("FAIL make_event got v=%b c=%h e=%b b=%b r=%b want 1 1d 0 0 0",
                     key_valid, key_code, key_ext, key_break, key_repeat);
        end
        total++;
        if ({keys_held, p1_dir, dir_changed} !== {8'h01, 2'b00, 2'b01}) begin
            bad++;
            $display("FAIL make_state got held=%h p1=%b dc=%b want 01 00 01",
                     keys_held, p1_dir, dir_changed);
        end
        idle(1);
        total++;
        if ({key_valid, dir_changed, key_code} !== {1'b0, 2'b00, 8'h1D}) begin
            bad++;
            $display("FAIL make_hold got v=%b dc=%b c=%h want 0 00 1d",
                     key_valid, dir_changed, key_code);
        end
    endtask

    task automatic test_ext();
        drive(8'hE0);
        total++;
        if (key_valid !== 1'b0) begin
            bad++;
            $display("FAIL ext_prefix_quiet got=%b want=0", key_valid);
        end
        drive(8'h74);
        total++;
        if ({key_valid, key_code, key_ext, key_break}
            !== {1'b1, 8'h74, 2'b10}) begin
            bad++;
            $display("FAIL ext_make got v=%b c=%h e=%b b=%b want 1 74 1 0",
                     key_valid, key_code, key_ext, key_break);
        end
        total++;
        if ({keys_held, p2_dir, dir_changed} !== {8'h21, 2'b11, 2'b00}) begin
            bad++;
            $display("FAIL ext_reverse got held=%h p2=%b dc=%b want 21 11 00",
                     keys_held, p2_dir, dir_changed);
        end
        vcount = 0;
        drive(8'hE0);
        drive(8'hF0);
        drive(8'h74);
        total++;
        if ({key_valid, key_code, key_ext, key_break, keys_held}
            !== {1'b1, 8'h74, 2'b11, 8'h01}) begin
            bad++;
            $display("FAIL ext_break got v=%b c=%h e=%b b=%b held=%h want 1 74 1 1 01",
                     key_valid, key_code, key_ext, key_break, keys_held);
        end
        idle(2);
        total++;
        if (vcount !== 1) begin
            bad++;
            $display("FAIL ext_break_count got=%0d want=1", vcount);
        end
    endtask

    task automatic test_repeat();
        do_reset();
        drive(8'h1D);
        total++;
        if ({key_valid, key_repeat, dir_changed} !== 4'b1_0_01) begin
            bad++;
            $display("FAIL rep_first got v=%b r=%b dc=%b want 1 0 01",
                     key_valid, key_repeat, dir_changed);
        end
        drive(8'h1D);
        total++;
        if ({key_valid, key_repeat, dir_changed} !== 4'b1_1_00) begin
            bad++;
            $display("FAIL rep_second got v=%b r=%b dc=%b want 1 1 00",
                     key_valid, key_repeat, dir_changed);
        end
        drive(8'h1D);
        total++;
        if ({key_valid, key_repeat, dir_changed} !== 4'b1_1_00) begin
            bad++;
            $display("FAIL rep_third got v=%b r=%b dc=%b want 1 1 00",
                     key_valid, key_repeat, dir_changed);
        end
        drive(8'h1B);
        total++;
        if ({key_valid, p1_dir, dir_changed, keys_held}
            !== {1'b1, 2'b00, 2'b00, 8'h05}) begin
            bad++;
            $display("FAIL rep_block got v=%b p1=%b dc=%b held=%h want 1 00 00 05",
                     key_valid, p1_dir, dir_changed, keys_held);
        end
        idle(1);
    endtask

    task automatic test_timeout();
        drive(8'hE0);
        vcount = 0;
        idle(TO + 5);
        total++;
        if (vcount !== 0) begin
            bad++;
            $display("FAIL to_quiet got=%0d want=0", vcount);
        end
        drive(8'h1C);
        total++;
        if ({key_valid, key_code, key_ext, key_break}
            !== {1'b1, 8'h1C, 2'b00}) begin
            bad++;
            $display("FAIL to_make got v=%b c=%h e=%b b=%b want 1 1c 0 0",
                     key_valid, key_code, key_ext, key_break);
        end
        total++;
        if ({p1_dir, dir_changed, keys_held} !== {2'b11, 2'b01, 8'h0D}) begin
            bad++;
            $display("FAIL to_dir got p1=%b dc=%b held=%h want 11 01 0d",
                     p1_dir, dir_changed, keys_held);
        end
        idle(1);
    endtask

    task automatic test_pause();
        vcount = 0;
        drive(8'hE1);
        drive(8'h14);
        drive(8'h77);
        drive(8'hE1);
        drive(8'hF0);
        drive(8'h14);
        drive(8'hF0);
        drive(8'h77);
        idle(2);
        total++;
        if (vcount !== 0) begin
            bad++;
            $display("FAIL pause_quiet got=%0d want=0", vcount);
        end
        drive(8'h1B);
        total++;
        if ({key_valid, key_code, key_ext, key_break, key_repeat}
            !== {1'b1, 8'h1B, 3'b001}) begin
            bad++;
            $display("FAIL pause_after got v=%b c=%h e=%b b=%b r=%b want 1 1b 0 0 1",
                     key_valid, key_code, key_ext, key_break, key_repeat);
        end
        total++;
        if ({p1_dir, dir_changed} !== 4'b10_01) begin
            bad++;
            $display("FAIL pause_dir got p1=%b dc=%b want 10 01",
                     p1_dir, dir_changed);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        drive(8'hE0);
        drive(8'h75);
        drive(8'hF0);
        bus.ps2_code_new = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if ({key_valid, key_code, keys_held, p1_dir, p2_dir, dir_changed}
            !== {1'b0, 8'h00, 8'h00, 2'b01, 2'b11, 2'b00}) begin
            bad++;
            $display("FAIL mid_reset got v=%b c=%h held=%h p1=%b p2=%b dc=%b want 0 00 00 01 11 00",
                     key_valid, key_code, keys_held, p1_dir, p2_dir, dir_changed);
        end
        drive(8'h1D);
        total++;
        if ({key_valid, key_break, key_repeat, keys_held, p1_dir, dir_changed}
            !== {3'b100, 8'h01, 2'b00, 2'b01}) begin
            bad++;
            $display("FAIL mid_after got v=%b b=%b r=%b held=%h p1=%b dc=%b want 1 0 0 01 00 01",
                     key_valid, key_break, key_repeat, keys_held, p1_dir, dir_changed);
        end
        idle(1);
    endtask

    initial begin
        bus.ps2_code_new = 1'b0;
        bus.ps2_code     = 8'h00;
        test_reset();
        test_make();
        test_ext();
        test_repeat();
        test_timeout();
        test_pause();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
